float_cmp_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754 comparator; next generation of the fixed double less-than block.
- Generalised over exponent/mantissa width, so one RTL covers single and double precision.
- Run-time predicate select covers EQ/NE/LT/LE/GT/GE/UNORDERED, with IEEE invalid flag.
- Full valid/ready streaming handshake with back-pressure and a sideband tag; used by float sort/max units and test harnesses.

---
 rtl/float_cmp_pipe_if.sv | 39 +++
 rtl/float_cmp_pipe.sv | 152 +++++++++++++++
 tb/tb_float_cmp_pipe.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_cmp_pipe_if.sv
// float_cmp_pipe_if
//   Streaming bus for the pipelined floating-point comparator.
//   Operand side : in_valid/in_ready handshake with in_a, in_b, in_op, in_tag.
//   Result side  : out_valid/out_ready handshake with out_z, out_invalid, out_tag.
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid && ready; the producer holds valid and payload steady until the
//   transfer, and ready never depends combinationally on valid.
//   master : the producer of operands / consumer of results (testbench, sorter).
//   slave  : the comparator itself.
`timescale 1ns/1ps
interface float_cmp_pipe_if #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    parameter int TAG_W = 8
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_z;
    logic             out_invalid;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_invalid, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_invalid, out_tag
    );
endinterface

// File: rtl/float_cmp_pipe.sv
// float_cmp_pipe
//   Two-stage pipelined IEEE-754 comparator, parametrised over exponent and
//   mantissa width. Stage 1 classifies the operands (NaN/sNaN/zero, signs,
//   magnitude order); stage 2 evaluates the selected predicate and the IEEE
//   invalid flag. Latency is 2 cycles from accept to out_valid when not stalled,
//   throughput one result per cycle.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset, discards all in-flight items
//     bus   : float_cmp_pipe_if slave modport
//             in_op encoding: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 UN, 7 reserved
`timescale 1ns/1ps
module float_cmp_pipe #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    float_cmp_pipe_if.slave      bus
);
    localparam int W = 1 + EXP_W + MAN_W;

    // ---------------- handshake ----------------
    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv, accept;

    // Each stage may take new data when it is empty or its content moves on.
    assign s2_adv   = !s2_valid || bus.out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign accept   = bus.in_valid && s1_adv;
    assign bus.in_ready = s1_adv;

    // ---------------- stage 1: classify ----------------
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_nan, b_nan, a_snan, b_snan, a_zero, b_zero;
    logic             c_mag_lt, c_mag_eq;

    assign a_exp  = bus.in_a[W-2:MAN_W];
    assign b_exp  = bus.in_b[W-2:MAN_W];
    assign a_man  = bus.in_a[MAN_W-1:0];
    assign b_man  = bus.in_b[MAN_W-1:0];
    assign a_nan  = (&a_exp) && (|a_man);
    assign b_nan  = (&b_exp) && (|b_man);
    // Signalling NaN has the quiet bit (mantissa MSB) clear.
    assign a_snan = a_nan && !a_man[MAN_W-1];
    assign b_snan = b_nan && !b_man[MAN_W-1];
    assign a_zero = ~|bus.in_a[W-2:0];
    assign b_zero = ~|bus.in_b[W-2:0];
    // {exp,man} as an unsigned integer orders magnitudes exactly, denormals
    // and infinities included.
    assign c_mag_lt = bus.in_a[W-2:0] <  bus.in_b[W-2:0];
    assign c_mag_eq = bus.in_a[W-2:0] == bus.in_b[W-2:0];

    logic             s1_nan_a, s1_nan_b, s1_snan_a, s1_snan_b;
    logic             s1_zero_a, s1_zero_b, s1_sign_a, s1_sign_b;
    logic             s1_mag_lt, s1_mag_eq;
    logic [2:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_nan_a  <= 1'b0;
            s1_nan_b  <= 1'b0;
            s1_snan_a <= 1'b0;
            s1_snan_b <= 1'b0;
            s1_zero_a <= 1'b0;
            s1_zero_b <= 1'b0;
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
            s1_mag_lt <= 1'b0;
            s1_mag_eq <= 1'b0;
            s1_op     <= 3'd0;
            s1_tag    <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (accept) begin
                s1_nan_a  <= a_nan;
                s1_nan_b  <= b_nan;
                s1_snan_a <= a_snan;
                s1_snan_b <= b_snan;
                s1_zero_a <= a_zero;
                s1_zero_b <= b_zero;
                s1_sign_a <= bus.in_a[W-1];
                s1_sign_b <= bus.in_b[W-1];
                s1_mag_lt <= c_mag_lt;
                s1_mag_eq <= c_mag_eq;
                s1_op     <= bus.in_op;
                s1_tag    <= bus.in_tag;
            end
        end
    end

    // ---------------- stage 2: evaluate ----------------
    logic unord, any_snan, both_zero, ord_eq, ord_lt, ord_gt;
    logic eval_z, eval_inv;

    always_comb begin
        unord     = s1_nan_a || s1_nan_b;
        any_snan  = s1_snan_a || s1_snan_b;
        both_zero = s1_zero_a && s1_zero_b;
        ord_eq    = both_zero || (s1_mag_eq && (s1_sign_a == s1_sign_b));
        if (both_zero)
            ord_lt = 1'b0;
        else if (s1_sign_a != s1_sign_b)
            ord_lt = s1_sign_a;                  // negative side is smaller
        else if (!s1_sign_a)
            ord_lt = s1_mag_lt;
        else
            ord_lt = !s1_mag_lt && !s1_mag_eq;   // both negative: larger magnitude is smaller
        ord_gt = !ord_lt && !ord_eq;

        eval_z   = 1'b0;
        eval_inv = 1'b0;
        case (s1_op)
            3'd0: begin eval_z = !unord && ord_eq;             eval_inv = any_snan; end
            3'd1: begin eval_z = unord || !ord_eq;             eval_inv = any_snan; end
            3'd2: begin eval_z = !unord && ord_lt;             eval_inv = unord;    end
            3'd3: begin eval_z = !unord && (ord_lt || ord_eq); eval_inv = unord;    end
            3'd4: begin eval_z = !unord && ord_gt;             eval_inv = unord;    end
            3'd5: begin eval_z = !unord && (ord_gt || ord_eq); eval_inv = unord;    end
            3'd6: begin eval_z = unord;                        eval_inv = any_snan; end
            default: begin eval_z = 1'b0;                      eval_inv = 1'b0;     end
        endcase
    end

    logic             s2_z, s2_invalid;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_z       <= 1'b0;
            s2_invalid <= 1'b0;
            s2_tag     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_z       <= eval_z;
                s2_invalid <= eval_inv;
                s2_tag     <= s1_tag;
            end
        end
    end

    assign bus.out_valid   = s2_valid;
    assign bus.out_z       = s2_z;
    assign bus.out_invalid = s2_invalid;
    assign bus.out_tag     = s2_tag;
endmodule

// File: tb/tb_float_cmp_pipe.sv
// tb_float_cmp_pipe
//   Bench for float_cmp_pipe: a double-precision instance (default parameters)
//   and a single-precision instance (EXP_W=8, MAN_W=23). Expected results come
//   from ref_cmp, which orders values by mapping them to monotone integer keys.
`timescale 1ns/1ps
module tb_float_cmp_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    float_cmp_pipe_if #(.EXP_W(11), .MAN_W(52), .TAG_W(8)) dif ();
    float_cmp_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(8)) sif ();

    float_cmp_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(8)) dut_dp (
        .clk(clk), .rst_n(rst_n), .bus(dif.slave)
    );
    float_cmp_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(8)) dut_sp (
        .clk(clk), .rst_n(rst_n), .bus(sif.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Returns {z, invalid}. Non-NaN values map to keys whose unsigned order is
    // the real-number order (zeros collapse onto one key).
    function automatic logic [1:0] ref_cmp(input logic [63:0] a, input logic [63:0] b,
                                           input logic [2:0] op, input int ew, input int mw);
        int w;
        logic [63:0] top, mask, emax, mmask, ka, kb;
        logic nan_a, nan_b, sn_a, sn_b, un, sn, lt, eq, gt, z, inv;
        w     = 1 + ew + mw;
        top   = 64'd1 << (w - 1);
        mask  = (top << 1) - 64'd1;
        emax  = (64'd1 << ew) - 64'd1;
        mmask = (64'd1 << mw) - 64'd1;
        nan_a = (((a >> mw) & emax) == emax) && ((a & mmask) != 0);
        nan_b = (((b >> mw) & emax) == emax) && ((b & mmask) != 0);
        sn_a  = nan_a && (((a >> (mw - 1)) & 64'd1) == 0);
        sn_b  = nan_b && (((b >> (mw - 1)) & 64'd1) == 0);
        ka = ((a & (top - 1)) == 0) ? top : (((a & top) != 0) ? (~a & mask) : (a | top));
        kb = ((b & (top - 1)) == 0) ? top : (((b & top) != 0) ? (~b & mask) : (b | top));
        un = nan_a || nan_b;
        sn = sn_a || sn_b;
        lt = ka < kb;
        eq = ka == kb;
        gt = ka > kb;
        case (op)
            3'd0: begin z = !un && eq;        inv = sn; end
            3'd1: begin z = un || !eq;        inv = sn; end
            3'd2: begin z = !un && lt;        inv = un; end
            3'd3: begin z = !un && (lt || eq); inv = un; end
            3'd4: begin z = !un && gt;        inv = un; end
            3'd5: begin z = !un && (gt || eq); inv = un; end
            3'd6: begin z = un;               inv = sn; end
            default: begin z = 1'b0;          inv = 1'b0; end
        endcase
        return {z, inv};
    endfunction

    function automatic logic [63:0] rand_dp(input logic [63:0] other);
        logic [63:0] v;
        case ($urandom_range(0, 9))
            0: begin v = 64'd0; v[63] = 1'($urandom_range(0, 1)); end
            1: begin v = 64'h7FF0000000000000; v[63] = 1'($urandom_range(0, 1)); end
            2: v = 64'h7FF8000000000000 | {32'd0, $urandom};
            3: v = 64'h7FF0000000000001 | {32'd0, $urandom};
            4: v = {$urandom, $urandom} & 64'h800FFFFFFFFFFFFF;
            5: v = other;
            6: v = other ^ 64'h8000000000000000;
            7: v = other ^ 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // ---------------- drivers ----------------
    // Issue one op into an empty pipe with out_ready=1; lat counts cycles from
    // the accepting cycle to the first cycle showing out_valid (20 = timeout).
    task automatic dp_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                         input logic [7:0] tag, output logic z, output logic inv,
                         output logic [7:0] otag, output int lat);
        @(posedge clk); #1;
        dif.in_a = a; dif.in_b = b; dif.in_op = op; dif.in_tag = tag;
        dif.in_valid = 1'b1; dif.out_ready = 1'b1;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!dif.out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        z = dif.out_z; inv = dif.out_invalid; otag = dif.out_tag;
    endtask

    task automatic sp_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         output logic z, output logic inv, output int lat);
        @(posedge clk); #1;
        sif.in_a = a; sif.in_b = b; sif.in_op = op; sif.in_tag = 8'h5A;
        sif.in_valid = 1'b1; sif.out_ready = 1'b1;
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!sif.out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        z = sif.out_z; inv = sif.out_invalid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        dif.in_valid = 1'b0; dif.out_ready = 1'b1;
        dif.in_a = '0; dif.in_b = '0; dif.in_op = '0; dif.in_tag = '0;
        sif.in_valid = 1'b0; sif.out_ready = 1'b1;
        sif.in_a = '0; sif.in_b = '0; sif.in_op = '0; sif.in_tag = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dif.out_valid, dif.out_z, dif.out_invalid, dif.out_tag} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b z=%b inv=%b tag=%h want all zero",
                     dif.out_valid, dif.out_z, dif.out_invalid, dif.out_tag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", dif.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [2:0] ops [7];
        logic       exp_z [7];
        logic z, inv;
        logic [7:0] otag;
        int lat;
        ops   = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd6};
        exp_z = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            dp_op(64'h3FF0000000000000, 64'h4000000000000000, ops[i], 8'(i + 8'h20), z, inv, otag, lat);
            checks++;
            if (lat !== 2 || z !== exp_z[i] || inv !== 1'b0 || otag !== 8'(i + 8'h20)) begin
                errors++;
                $display("FAIL basic_op%0d got lat=%0d z=%b inv=%b tag=%h want lat=2 z=%b inv=0 tag=%h",
                         ops[i], lat, z, inv, otag, exp_z[i], 8'(i + 8'h20));
            end
        end
    endtask

    task automatic test_signs_zeros_nans();
        logic [63:0] a [7];
        logic [63:0] b [7];
        logic [2:0]  op [7];
        logic [1:0]  want [7];
        logic z, inv;
        logic [7:0] otag;
        int lat;
        a    = '{64'hBFF0000000000000, 64'h8000000000000000, 64'h8000000000000000,
                 64'h7FF8000000000000, 64'h7FF8000000000000, 64'h7FF8000000000000,
                 64'h7FF0000000000001};
        b    = '{64'h8000000000000000, 64'h0000000000000000, 64'h0000000000000000,
                 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000,
                 64'h3FF0000000000000};
        op   = '{3'd2, 3'd0, 3'd2, 3'd2, 3'd0, 3'd6, 3'd0};
        want = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
        for (int i = 0; i < 7; i++) begin
            dp_op(a[i], b[i], op[i], 8'(i), z, inv, otag, lat);
            checks++;
            if ({z, inv} !== want[i] || lat !== 2) begin
                errors++;
                $display("FAIL special_%0d got z=%b inv=%b lat=%0d want z=%b inv=%b lat=2",
                         i, z, inv, lat, want[i][1], want[i][0]);
            end
        end
        dp_op(64'h3FF0000000000000, 64'h3FF0000000000000, 3'd7, 8'hAA, z, inv, otag, lat);
        checks++;
        if ({z, inv} !== 2'b00) begin
            errors++;
            $display("FAIL reserved_op got z=%b inv=%b want z=0 inv=0", z, inv);
        end
    endtask

    // Streams n ops with random gaps and out_ready either on a 1,0,0,1 pattern
    // with occasional flips (bp=1) or random (bp=0); checks order, tags, results,
    // stall stability and when in_ready may be low.
    task automatic run_stream(input int n, input bit bp, input string name);
        logic [9:0] exp_q[$];
        logic [9:0] want, held;
        logic [1:0] r;
        logic [63:0] a;
        bit stall_prev, acc;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; stall_prev = 0; acc = 0; held = '0;
        dif.in_valid = 1'b0;
        while (got < n && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (acc || !dif.in_valid) begin
                if (sent < n && $urandom_range(0, 4) != 0) begin
                    a = rand_dp({$urandom, $urandom});
                    dif.in_a = a;
                    dif.in_b = rand_dp(a);
                    dif.in_op = 3'($urandom_range(0, 7));
                    dif.in_tag = 8'(sent);
                    dif.in_valid = 1'b1;
                end else begin
                    dif.in_valid = 1'b0;
                end
            end
            if (bp)
                dif.out_ready = ((cyc % 4 == 0) || (cyc % 4 == 3)) ^ ($urandom_range(0, 7) == 0);
            else
                dif.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++;
            if (dif.in_ready !== !(exp_q.size() == 2 && !dif.out_ready)) begin
                errors++;
                $display("FAIL %s_in_ready cyc=%0d got %b with %0d in flight out_ready=%b",
                         name, cyc, dif.in_ready, exp_q.size(), dif.out_ready);
            end
            if (stall_prev) begin
                checks++;
                if (dif.out_valid !== 1'b1 || {dif.out_tag, dif.out_z, dif.out_invalid} !== held) begin
                    errors++;
                    $display("FAIL %s_stall_hold cyc=%0d got v=%b %h want v=1 %h",
                             name, cyc, dif.out_valid, {dif.out_tag, dif.out_z, dif.out_invalid}, held);
                end
            end
            stall_prev = dif.out_valid && !dif.out_ready;
            held = {dif.out_tag, dif.out_z, dif.out_invalid};
            if (dif.out_valid && dif.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_result got tag=%h want none", name, dif.out_tag);
                end else begin
                    want = exp_q.pop_front();
                    if ({dif.out_tag, dif.out_z, dif.out_invalid} !== want) begin
                        errors++;
                        $display("FAIL %s_result got tag=%h z=%b inv=%b want tag=%h z=%b inv=%b",
                                 name, dif.out_tag, dif.out_z, dif.out_invalid,
                                 want[9:2], want[1], want[0]);
                    end
                end
                got++;
            end
            acc = dif.in_valid && dif.in_ready;
            if (acc) begin
                r = ref_cmp(dif.in_a, dif.in_b, dif.in_op, 11, 52);
                exp_q.push_back({dif.in_tag, r});
                sent++;
            end
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_count got %0d results want %0d", name, got, n);
        end
        @(posedge clk); #1;
        dif.in_valid = 1'b0; dif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        run_stream(16, 1'b1, "backpressure");
        run_stream(300, 1'b0, "random");
    endtask

    task automatic test_reset_mid_stream();
        logic z, inv;
        logic [7:0] otag;
        int lat;
        bit stale;
        @(posedge clk); #1;
        dif.out_ready = 1'b0;
        dif.in_a = 64'h3FF0000000000000; dif.in_b = 64'h4000000000000000;
        dif.in_op = 3'd2; dif.in_tag = 8'h11; dif.in_valid = 1'b1;
        @(posedge clk); #1;
        dif.in_tag = 8'h12;
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_precondition got out_valid=%b want 1", dif.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dif.out_valid, dif.out_z, dif.out_invalid, dif.out_tag} !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_async got v=%b z=%b inv=%b tag=%h want all zero",
                     dif.out_valid, dif.out_z, dif.out_invalid, dif.out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dif.out_ready = 1'b1;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (dif.out_valid !== 1'b0) stale = 1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL rst_mid_stale got out_valid=1 after reset want 0");
        end
        dp_op(64'hC000000000000000, 64'hBFF0000000000000, 3'd2, 8'h33, z, inv, otag, lat);
        checks++;
        if (lat !== 2 || z !== 1'b1 || inv !== 1'b0 || otag !== 8'h33) begin
            errors++;
            $display("FAIL rst_mid_next got lat=%0d z=%b inv=%b tag=%h want lat=2 z=1 inv=0 tag=33",
                     lat, z, inv, otag);
        end
    endtask

    task automatic test_single();
        logic z, inv;
        logic [1:0] r;
        logic [31:0] a, b;
        int lat;
        sp_op(32'h7F800000, 32'h7F7FFFFF, 3'd4, z, inv, lat);
        checks++;
        if (z !== 1'b1 || inv !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL sp_inf_gt got z=%b inv=%b lat=%0d want z=1 inv=0 lat=2", z, inv, lat);
        end
        sp_op(32'h00000001, 32'h00000000, 3'd2, z, inv, lat);
        checks++;
        if (z !== 1'b0 || inv !== 1'b0) begin
            errors++;
            $display("FAIL sp_denorm_lt got z=%b inv=%b want z=0 inv=0", z, inv);
        end
        sp_op(32'h00000001, 32'h00000000, 3'd4, z, inv, lat);
        checks++;
        if (z !== 1'b1 || inv !== 1'b0) begin
            errors++;
            $display("FAIL sp_denorm_gt got z=%b inv=%b want z=1 inv=0", z, inv);
        end
        for (int i = 0; i < 40; i++) begin
            a = rand_dp({$urandom, $urandom})[31:0];
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ 32'h80000000;
                2: b = {a[31], 8'hFF, 1'b0, 22'($urandom_range(1, 1000))};
                default: b = $urandom;
            endcase
            if (i % 5 == 0) a = {1'b0, 8'hFF, 1'b1, 22'($urandom)};
            r = ref_cmp({32'd0, a}, {32'd0, b}, 3'(i % 8), 8, 23);
            sp_op(a, b, 3'(i % 8), z, inv, lat);
            checks++;
            if ({z, inv} !== r || lat !== 2) begin
                errors++;
                $display("FAIL sp_random a=%h b=%h op=%0d got z=%b inv=%b lat=%0d want z=%b inv=%b lat=2",
                         a, b, i % 8, z, inv, lat, r[1], r[0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_signs_zeros_nans();
        test_back_to_back();
        test_reset_mid_stream();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
